// File: rtl/axi_pim_pkg.sv
// Shared definitions for the PIM AXI burst master, its bus interface and bench.
package axi_pim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AXI size encoding for a full-width beat: log2 of the bytes per beat.
  function automatic logic [2:0] axi_size(input int strb_width);
    return 3'($clog2(strb_width));
  endfunction

endpackage

// File: rtl/axi_pim_master_if.sv
// Full AXI4 bus between the PIM burst master and the PIM RAM slave.
interface axi_pim_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
);
  // write address channel
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  // write data channel
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  // write response channel
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  // read address channel
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  // read data channel
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_pim_master.sv
// Single-outstanding AXI4 INCR burst initiator driving the PIM RAM slave from
// a command port plus write/read data streams.
module axi_pim_master
  import axi_pim_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  axi_pim_master_if.master      m_axi
);

  localparam logic [2:0]            AXI_SIZE  = axi_size(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  awvalid_q, awvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  err_acc_q, err_acc_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic in_w, in_r, last_beat;
  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic b_bad, r_bad;

  assign in_w      = (state_q == ST_W);
  assign in_r      = (state_q == ST_R);
  assign last_beat = (cnt_q == 8'd0);

  assign accept = cmd_valid && (state_q == ST_IDLE);
  assign aw_hs  = awvalid_q && m_axi.awready;
  assign w_hs   = in_w && wr_valid && m_axi.wready;
  assign b_hs   = (state_q == ST_B) && m_axi.bvalid;
  assign ar_hs  = arvalid_q && m_axi.arready;
  assign r_hs   = in_r && m_axi.rvalid && rd_ready;

  // The slave's last flag is only checked against our own beat count, never trusted.
  assign b_bad = (m_axi.bresp != RESP_OKAY) || (m_axi.bid != id_q);
  assign r_bad = (m_axi.rresp != RESP_OKAY) || (m_axi.rid != id_q) ||
                 (m_axi.rlast != last_beat);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    // NOTE: clocked state always uses <= so every flop samples pre-edge values.
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)              state_d = cmd_write ? ST_AW : ST_AR;
      ST_AW:   if (aw_hs)               state_d = ST_W;
      ST_W:    if (w_hs && last_beat)   state_d = ST_B;
      ST_B:    if (b_hs)                state_d = ST_IDLE;
      ST_AR:   if (ar_hs)               state_d = ST_R;
      ST_R:    if (r_hs && last_beat)   state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Stream/AXI handshake outputs decoded from the current state
  always_comb begin
    cmd_ready    = (state_q == ST_IDLE);
    busy         = (state_q != ST_IDLE);
    wr_ready     = in_w && m_axi.wready;
    m_axi.wvalid = in_w && wr_valid;
    m_axi.wlast  = in_w && last_beat;
    m_axi.bready = (state_q == ST_B);
    m_axi.rready = in_r && rd_ready;
    rd_valid     = in_r && m_axi.rvalid;
    rd_last      = in_r && last_beat;
  end

  // Burst parameters, beat counter and status next values
  always_comb begin
    addr_d    = addr_q;
    len_d     = len_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    err_d     = err_q;
    done_d    = 1'b0;
    awvalid_d = (state_d == ST_AW);
    arvalid_d = (state_d == ST_AR);

    if (accept) begin
      addr_d    = cmd_addr & ~ADDR_MASK;
      len_d     = cmd_len;
      id_d      = cmd_id;
      cnt_d     = cmd_len;
      err_acc_d = 1'b0;
      err_d     = 1'b0;
    end

    if (w_hs) cnt_d = cnt_q - 8'd1;

    if (b_hs) begin
      err_d  = b_bad;
      done_d = 1'b1;
    end

    // Mid-burst read errors are collected and published together with done.
    if (r_hs) begin
      cnt_d = cnt_q - 8'd1;
      if (last_beat) begin
        err_d  = err_acc_q || r_bad;
        done_d = 1'b1;
      end else begin
        err_acc_d = err_acc_q || r_bad;
      end
    end
  end

  // Burst parameter, counter and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      err_acc_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      awvalid_q <= awvalid_d;
      arvalid_q <= arvalid_d;
      err_acc_q <= err_acc_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign done = done_q;
  assign err  = err_q;

  assign m_axi.awid    = id_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = AXI_SIZE;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'd0;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awvalid = awvalid_q;

  assign m_axi.wdata   = wr_data;
  assign m_axi.wstrb   = '1;

  assign m_axi.arid    = id_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = AXI_SIZE;
  assign m_axi.arburst = BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'd0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arvalid = arvalid_q;

  assign rd_data = m_axi.rdata;

endmodule
